spram_req_adapter: RTL and testbench
====================================

Name: spram_req_adapter

Overview:
- Bridges a valid/ready request/response port to one single-port RAM macro with active-low CEN/WEN and 1-cycle registered read data.
- The RAM's Q is only meaningful in the cycle after a read; at all other times it holds garbage. This block captures Q at exactly the right cycle and holds it until the consumer takes it.
- It implements byte-strobed writes via read-modify-write, because the RAM has no byte mask.
- It sits directly upstream of the RAM, between the core/cache request logic and the macro.

Parameters:
- DATA_WIDTH, 32, RAM word width; multiple of 8.
- DEPTH, 1024, RAM word count; ADDR_W = $clog2(DEPTH); STRB_W = DATA_WIDTH/8.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid&&ready.
- req_wen  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_wstrb  in  STRB_W  byte enables; ignored for reads.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed when valid&&ready.
- resp_rdata  out  DATA_WIDTH  read data; 0 for write acks.
- sram_cen  out  1  RAM chip enable, active-low.
- sram_wen  out  1  RAM write enable, active-low (1 = read).
- sram_a  out  ADDR_W  RAM address.
- sram_d  out  DATA_WIDTH  RAM write data.
- sram_q  in  DATA_WIDTH  RAM read data; valid only the cycle after a read.

Behaviour:
- States:
  - IDLE.
  - RD_DATA: Q valid this cycle.
  - RMW: Q valid, merge and write.
  - RESP: holding response.
- One request outstanding. req_ready = (state==IDLE) && !RST.
- Reset (async, any state, mid-op included): state=IDLE, resp_valid=0, hold register=0, sram_cen=1, sram_wen=1, sram_a=0, sram_d=0.
- SRAM outputs are combinational from state and the accept condition. When not accessing: cen=1, wen=1, a=0, d=0.
- Read accepted at cycle T:
  - T: cen=0, wen=1, a=req_addr. Go to RD_DATA.
  - T+1: resp_valid=1, resp_rdata=sram_q (pass-through).
  - If resp_ready, go to IDLE. Otherwise latch sram_q into the hold register and go to RESP.
- Full write (wstrb all ones) accepted at T:
  - T: cen=0, wen=0, a=req_addr, d=req_wdata.
  - Go to RESP with hold=0; ack visible at T+1.
- Partial write (wstrb neither all ones nor zero) accepted at T:
  - T: read issued. Latch addr, wdata and wstrb. Go to RMW.
  - T+1: cen=0, wen=0, same addr. d = per byte i, wstrb[i] ? wdata byte : sram_q byte. Go to RESP with hold=0.
  - Ack visible at T+2.
- Zero-strobe write: no RAM access (cen stays 1). Go to RESP; ack at T+1.
- RESP: resp_valid=1, resp_rdata=hold. Go to IDLE on resp_ready.
- resp_rdata is 0 whenever resp_valid=0.
- Request inputs are sampled only in the accept cycle; later changes have no effect.

Optional Feature:
- Macro: SPRAM_REQ_ADAPTER_PIPE_EN.
- Defined:
  - req_ready is also 1 in RD_DATA or RESP when resp_ready=1, so a new request is accepted in the same cycle the response completes. Back-to-back reads sustain 1 per cycle.
  - A combinational path resp_ready→req_ready is permitted.
  - The new request follows the same per-type sequencing from that cycle.
- Undefined: req_ready only in IDLE. Minimum read-to-read spacing is 2 cycles.

Decomposition:
- Package spram_req_adapter_pkg:
  - state enum (IDLE, RD_DATA, RMW, RESP).
  - function strb_full(wstrb).
  - function strb_zero(wstrb).
- Sub-module spram_byte_merge: combinational per-byte mux (old, new, strb) → merged. It is parameterised on DATA_WIDTH.
- The bench instantiates the RAM model itself; this block does not.

Test Plan:
- Reset, then read addr 5 (RAM preloaded 0xDEADBEEF), resp_ready=1 → cen=0/wen=1 at T; resp_valid=1 and rdata=0xDEADBEEF at T+1; req_ready=1 at T+2.
- Read addr 5 with resp_ready held 0 for 3 cycles → rdata stays 0xDEADBEEF through RESP despite RAM Q randomising; single response on release.
- Full write addr 7 data 0x12345678 strb 0xF, then read addr 7 → ack at T+1 with rdata=0; read returns 0x12345678.
- Addr 7 = 0x12345678; write 0xAABBCCDD strb 0x5 → read cycle then write cycle observed; subsequent read returns 0x12BB56DD; ack at T+2.
- Write strb 0x0 → cen never 0; ack at T+1; RAM contents unchanged.
- RST asserted during RMW (after read cycle) → outputs immediately at reset values; no write issued; first request after release behaves normally.
- With SPRAM_REQ_ADAPTER_PIPE_EN, reads to addrs 0,1,2,3 with valid and resp_ready held 1 → one response per cycle, in order.

Source files
------------

// File: rtl/spram_req_adapter_pkg.sv
// Shared types and strobe helpers for the single-port RAM request adapter.
// Optional build macro used by the adapter: SPRAM_REQ_ADAPTER_PIPE_EN.
package spram_req_adapter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_DATA = 2'd1,
      ST_RMW     = 2'd2,
      ST_RESP    = 2'd3
   } state_t;

   localparam int MAX_STRB_W = 64;

   // Callers zero-extend their strobe to MAX_STRB_W and pass the real width.
   function automatic logic strb_full(input logic [MAX_STRB_W-1:0] wstrb, input int w);
      logic full;
      full = 1'b1;
      for (int i = 0; i < MAX_STRB_W; i++) begin
         if (i < w && !wstrb[i]) full = 1'b0;
      end
      return full;
   endfunction

   function automatic logic strb_zero(input logic [MAX_STRB_W-1:0] wstrb);
      return (wstrb == '0);
   endfunction

endpackage

// File: rtl/spram_byte_merge.sv
// Per-byte merge of new write data over the word read back from the RAM.
module spram_byte_merge #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0]   old_data,
   input  logic [DATA_WIDTH-1:0]   new_data,
   input  logic [DATA_WIDTH/8-1:0] strb,
   output logic [DATA_WIDTH-1:0]   merged
);

   always_comb begin
      merged = old_data;
      for (int i = 0; i < DATA_WIDTH/8; i++) begin
         if (strb[i]) merged[i*8 +: 8] = new_data[i*8 +: 8];
      end
   end

endmodule

// File: rtl/spram_req_adapter.sv
// Valid/ready request port to single-port RAM bridge with read-modify-write byte strobes.
// Build macro SPRAM_REQ_ADAPTER_PIPE_EN lets a new request enter as a response completes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no request outstanding, ready to accept
// RD_DATA  | RAM Q valid this cycle, passed straight to resp_rdata
// RMW      | RAM Q valid, merged with latched write data and written back
// RESP     | response held in hold register until consumer takes it
module spram_req_adapter
   import spram_req_adapter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 1024,
   localparam int ADDR_W    = $clog2(DEPTH),
   localparam int STRB_W    = DATA_WIDTH/8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wen,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [STRB_W-1:0]     req_wstrb,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  sram_cen,
   output logic                  sram_wen,
   output logic [ADDR_W-1:0]     sram_a,
   output logic [DATA_WIDTH-1:0] sram_d,
   input  logic [DATA_WIDTH-1:0] sram_q
);

   state_t                  state;
   logic [DATA_WIDTH-1:0]   hold;
   logic [ADDR_W-1:0]       lat_addr;
   logic [DATA_WIDTH-1:0]   lat_wdata;
   logic [STRB_W-1:0]       lat_wstrb;
   logic [DATA_WIDTH-1:0]   merged;
   logic                    accept;
   logic                    is_full;
   logic                    is_zero;

   assign is_full = strb_full(MAX_STRB_W'(req_wstrb), STRB_W);
   assign is_zero = strb_zero(MAX_STRB_W'(req_wstrb));

   spram_byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
      .old_data (sram_q),
      .new_data (lat_wdata),
      .strb     (lat_wstrb),
      .merged   (merged)
   );

   always_comb begin
      req_ready = 1'b0;
      if (!RST) begin
         if (state == ST_IDLE) begin
            req_ready = 1'b1;
         end
`ifdef SPRAM_REQ_ADAPTER_PIPE_EN
         else if ((state == ST_RD_DATA || state == ST_RESP) && resp_ready) begin
            req_ready = 1'b1;
         end
`endif
      end
   end

   assign accept = req_valid && req_ready;

   // A partial write starts as a plain read; the merged write follows in RMW.
   always_comb begin
      sram_cen = 1'b1;
      sram_wen = 1'b1;
      sram_a   = '0;
      sram_d   = '0;
      if (state == ST_RMW) begin
         sram_cen = 1'b0;
         sram_wen = 1'b0;
         sram_a   = lat_addr;
         sram_d   = merged;
      end else if (accept) begin
         if (!req_wen) begin
            sram_cen = 1'b0;
            sram_a   = req_addr;
         end else if (is_full) begin
            sram_cen = 1'b0;
            sram_wen = 1'b0;
            sram_a   = req_addr;
            sram_d   = req_wdata;
         end else if (!is_zero) begin
            sram_cen = 1'b0;
            sram_a   = req_addr;
         end
      end
   end

   assign resp_valid = (state == ST_RD_DATA) || (state == ST_RESP);

   always_comb begin
      resp_rdata = '0;
      if (state == ST_RD_DATA) resp_rdata = sram_q;
      else if (state == ST_RESP) resp_rdata = hold;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= ST_IDLE;
         hold      <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_wstrb <= '0;
      end else if (accept) begin
         lat_addr  <= req_addr;
         lat_wdata <= req_wdata;
         lat_wstrb <= req_wstrb;
         hold      <= '0;
         if (!req_wen)                  state <= ST_RD_DATA;
         else if (!is_full && !is_zero) state <= ST_RMW;
         else                           state <= ST_RESP;
      end else begin
         case (state)
            ST_RD_DATA: begin
               if (resp_ready) begin
                  state <= ST_IDLE;
               end else begin
                  hold  <= sram_q;
                  state <= ST_RESP;
               end
            end
            ST_RMW: begin
               hold  <= '0;
               state <= ST_RESP;
            end
            ST_RESP: begin
               if (resp_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spram_req_adapter.sv
// Self-checking bench for spram_req_adapter: directed timing cases plus a randomized
// run against a queue/array reference model; the bench owns the RAM model.
module tb_spram_req_adapter;

   localparam int DW = 32;
   localparam int DEPTH = 1024;
   localparam int AW = 10;
   localparam int SW = 4;

   logic          CLK;
   logic          RST;
   logic          req_valid;
   logic          req_ready;
   logic          req_wen;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [SW-1:0] req_wstrb;
   logic          resp_valid;
   logic          resp_ready;
   logic [DW-1:0] resp_rdata;
   logic          sram_cen;
   logic          sram_wen;
   logic [AW-1:0] sram_a;
   logic [DW-1:0] sram_d;
   logic [DW-1:0] sram_q;

   int n_chk = 0;
   int n_bad = 0;
   int n_cen = 0;

   logic [DW-1:0] ram [DEPTH];
   logic          pl_en;
   logic [AW-1:0] pl_addr;
   logic [DW-1:0] pl_data;

   logic [DW-1:0] ref_mem [16];
   logic [DW-1:0] exp_q [$];

   spram_req_adapter #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wen    (req_wen),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_wstrb  (req_wstrb),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .sram_cen   (sram_cen),
      .sram_wen   (sram_wen),
      .sram_a     (sram_a),
      .sram_d     (sram_d),
      .sram_q     (sram_q)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // RAM model: Q holds read data only the cycle after a read, garbage otherwise.
   always @(posedge CLK) begin
      if (pl_en) begin
         ram[pl_addr] <= pl_data;
         sram_q       <= $urandom;
      end else if (!sram_cen && !sram_wen) begin
         ram[sram_a] <= sram_d;
         sram_q      <= $urandom;
      end else if (!sram_cen) begin
         sram_q <= ram[sram_a];
      end else begin
         sram_q <= $urandom;
      end
      if (!sram_cen) n_cen <= n_cen + 1;
   end

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge CLK);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(negedge CLK);
      pl_en = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
      int n;
      @(negedge CLK);
      req_valid = 1'b1; req_wen = 1'b0; req_addr = a; resp_ready = 1'b1;
      #1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge CLK); #1; n++;
      end
      @(negedge CLK);
      req_valid = 1'b0;
      #1;
      n = 0;
      while (!resp_valid && n < 20) begin
         @(negedge CLK); #1; n++;
      end
      if (resp_valid) chk(tag, resp_rdata, exp);
      else chk({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       accepted;
      logic [3:0] ra;
      int         n;
      int         cen_before;
      logic [DW-1:0] merged;

      RST = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      resp_ready = 1'b0;

      repeat (2) @(negedge CLK);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_cen", 32'(sram_cen), 32'd1);
      chk("rst_wen", 32'(sram_wen), 32'd1);
      chk("rst_a", 32'(sram_a), 32'd0);
      chk("rst_d", sram_d, 32'd0);
      @(negedge CLK);
      RST = 1'b0;

      preload(10'd5, 32'hDEADBEEF);
      preload(10'd7, 32'h0);
      preload(10'd9, 32'hCAFEF00D);

      // Read with immediate consume
      @(negedge CLK);
      req_valid = 1'b1; req_wen = 1'b0; req_addr = 10'd5; resp_ready = 1'b1;
      #1;
      chk("rd_req_ready", 32'(req_ready), 32'd1);
      chk("rd_cen", 32'(sram_cen), 32'd0);
      chk("rd_wen", 32'(sram_wen), 32'd1);
      chk("rd_a", 32'(sram_a), 32'd5);
      chk("rd_no_early_resp", 32'(resp_valid), 32'd0);
      @(negedge CLK);
      req_valid = 1'b0;
      #1;
      chk("rd_resp_valid", 32'(resp_valid), 32'd1);
      chk("rd_rdata", resp_rdata, 32'hDEADBEEF);
      @(negedge CLK);
      #1;
      chk("rd_ready_t2", 32'(req_ready), 32'd1);
      chk("rd_resp_done", 32'(resp_valid), 32'd0);

      // Read with stalled consumer
      @(negedge CLK);
      req_valid = 1'b1; req_addr = 10'd5; resp_ready = 1'b0;
      #1;
      chk("stall_req_ready", 32'(req_ready), 32'd1);
      @(negedge CLK);
      req_valid = 1'b0;
      #1;
      chk("stall_rdata_t1", resp_rdata, 32'hDEADBEEF);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK); #1;
         chk("stall_valid", 32'(resp_valid), 32'd1);
         chk("stall_rdata", resp_rdata, 32'hDEADBEEF);
         chk("stall_no_ready", 32'(req_ready), 32'd0);
      end
      @(negedge CLK);
      resp_ready = 1'b1;
      #1;
      chk("stall_release", resp_rdata, 32'hDEADBEEF);
      @(negedge CLK); #1;
      chk("stall_single_resp", 32'(resp_valid), 32'd0);

      // Full write
      @(negedge CLK);
      req_valid = 1'b1; req_wen = 1'b1; req_addr = 10'd7; req_wdata = 32'h12345678; req_wstrb = 4'hF;
      #1;
      chk("fw_cen", 32'(sram_cen), 32'd0);
      chk("fw_wen", 32'(sram_wen), 32'd0);
      chk("fw_a", 32'(sram_a), 32'd7);
      chk("fw_d", sram_d, 32'h12345678);
      @(negedge CLK);
      req_valid = 1'b0;
      #1;
      chk("fw_ack_valid", 32'(resp_valid), 32'd1);
      chk("fw_ack_rdata", resp_rdata, 32'd0);
      do_read(10'd7, 32'h12345678, "fw_readback");

      // Partial write via read-modify-write
      @(negedge CLK);
      req_valid = 1'b1; req_wen = 1'b1; req_addr = 10'd7; req_wdata = 32'hAABBCCDD; req_wstrb = 4'h5;
      #1;
      chk("pw_rd_cen", 32'(sram_cen), 32'd0);
      chk("pw_rd_wen", 32'(sram_wen), 32'd1);
      chk("pw_rd_a", 32'(sram_a), 32'd7);
      @(negedge CLK);
      req_valid = 1'b0; req_wdata = 32'h0; req_wstrb = 4'hF; req_addr = 10'd0;
      #1;
      chk("pw_wr_cen", 32'(sram_cen), 32'd0);
      chk("pw_wr_wen", 32'(sram_wen), 32'd0);
      chk("pw_wr_a", 32'(sram_a), 32'd7);
      chk("pw_wr_d", sram_d, 32'h12BB56DD);
      chk("pw_no_early_ack", 32'(resp_valid), 32'd0);
      @(negedge CLK); #1;
      chk("pw_ack_valid", 32'(resp_valid), 32'd1);
      chk("pw_ack_rdata", resp_rdata, 32'd0);
      do_read(10'd7, 32'h12BB56DD, "pw_readback");

      // Zero-strobe write
      cen_before = n_cen;
      @(negedge CLK);
      req_valid = 1'b1; req_wen = 1'b1; req_addr = 10'd7; req_wdata = 32'hFFFFFFFF; req_wstrb = 4'h0;
      #1;
      chk("zw_accept", 32'(req_ready), 32'd1);
      chk("zw_cen", 32'(sram_cen), 32'd1);
      @(negedge CLK);
      req_valid = 1'b0;
      #1;
      chk("zw_ack_valid", 32'(resp_valid), 32'd1);
      chk("zw_ack_rdata", resp_rdata, 32'd0);
      @(negedge CLK); #1;
      chk("zw_no_access", 32'(n_cen - cen_before), 32'd0);
      chk("zw_ram_kept", ram[7], 32'h12BB56DD);

      // Reset while in the RMW write cycle
      @(negedge CLK);
      req_valid = 1'b1; req_wen = 1'b1; req_addr = 10'd9; req_wdata = 32'h11111111; req_wstrb = 4'h3;
      #1;
      chk("rr_rd_wen", 32'(sram_wen), 32'd1);
      @(negedge CLK);
      req_valid = 1'b0;
      #1;
      chk("rr_in_rmw", 32'(sram_wen), 32'd0);
      RST = 1'b1;
      #1;
      chk("rr_cen", 32'(sram_cen), 32'd1);
      chk("rr_wen", 32'(sram_wen), 32'd1);
      chk("rr_a", 32'(sram_a), 32'd0);
      chk("rr_d", sram_d, 32'd0);
      chk("rr_resp_valid", 32'(resp_valid), 32'd0);
      chk("rr_req_ready", 32'(req_ready), 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      chk("rr_ram_kept", ram[9], 32'hCAFEF00D);
      chk("rr_idle_after", 32'(resp_valid), 32'd0);
      do_read(10'd9, 32'hCAFEF00D, "rr_readback");

`ifdef SPRAM_REQ_ADAPTER_PIPE_EN
      for (int i = 0; i < 4; i++) preload(AW'(i), 32'hA0000000 + 32'(i));
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         req_valid = (i < 4); req_wen = 1'b0; req_addr = AW'(i); resp_ready = 1'b1;
         #1;
         if (i < 4) chk("pipe_req_ready", 32'(req_ready), 32'd1);
         if (i > 0) begin
            chk("pipe_resp_valid", 32'(resp_valid), 32'd1);
            chk("pipe_rdata", resp_rdata, 32'hA0000000 + 32'(i - 1));
         end
      end
      @(negedge CLK);
      req_valid = 1'b0;
`endif

      // Randomized traffic against the reference model
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = $urandom;
         preload(AW'(i), ref_mem[i]);
      end
      accepted = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge CLK);
         if (accepted) req_valid = 1'b0;
         accepted = 1'b0;
         if (!req_valid && $urandom_range(0, 2) != 0) begin
            req_valid = 1'b1;
            req_wen   = $urandom_range(0, 1) == 1;
            req_addr  = AW'($urandom_range(0, 15));
            req_wdata = $urandom;
            case ($urandom_range(0, 3))
               0:       req_wstrb = 4'hF;
               1:       req_wstrb = 4'h0;
               default: req_wstrb = 4'($urandom_range(0, 15));
            endcase
         end
         resp_ready = $urandom_range(0, 3) != 0;
         #1;
         if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) chk("rand_spurious_resp", 32'd1, 32'd0);
            else chk("rand_resp", resp_rdata, exp_q.pop_front());
         end else if (!resp_valid) begin
            chk("rand_idle_rdata", resp_rdata, 32'd0);
         end
         if (req_valid && req_ready) begin
            ra = req_addr[3:0];
            if (!req_wen) begin
               exp_q.push_back(ref_mem[ra]);
            end else begin
               merged = ref_mem[ra];
               for (int b = 0; b < SW; b++)
                  if (req_wstrb[b]) merged[b*8 +: 8] = req_wdata[b*8 +: 8];
               ref_mem[ra] = merged;
               exp_q.push_back(32'd0);
            end
            accepted = 1'b1;
         end
      end
      @(negedge CLK);
      if (accepted) req_valid = 1'b0;
      resp_ready = 1'b1;
      n = 0;
      #1;
      while (exp_q.size() != 0 && n < 20) begin
         if (resp_valid) chk("drain_resp", resp_rdata, exp_q.pop_front());
         @(negedge CLK); #1; n++;
      end
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
      @(negedge CLK); #1;
      for (int i = 0; i < 16; i++) chk("rand_ram_final", ram[i], ref_mem[i]);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
